// File: rtl/seq_detect_sched_pkg.sv
// Shared constants for the round-robin serial run-of-ones detector.
// State encodings and default geometry used by every file of the block.
package seq_sched_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] RESP  = 2'd2;

    localparam int DEF_N_REQ   = 4;
    localparam int DEF_WORD_W  = 8;
    localparam int DEF_RUN_LEN = 3;

endpackage

// File: rtl/seq_detect_sched_if.sv
// Request/response bundle between word sources and the shared detector.
// master = requester/consumer side, slave = detector side.
interface seq_detect_sched_if
    import seq_sched_pkg::*;
#(
    parameter int N_REQ  = DEF_N_REQ,
    parameter int WORD_W = DEF_WORD_W,
    parameter int ID_W   = $clog2(N_REQ),
    parameter int CNT_W  = $clog2(WORD_W + 1)
);

    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*WORD_W-1:0] req_data;
    logic [N_REQ-1:0]        req_ready;
    logic                    rsp_valid;
    logic [ID_W-1:0]         rsp_id;
    logic [CNT_W-1:0]        rsp_count;
    logic                    rsp_ready;

    modport master (
        output req_valid,
        output req_data,
        output rsp_ready,
        input  req_ready,
        input  rsp_valid,
        input  rsp_id,
        input  rsp_count
    );

    modport slave (
        input  req_valid,
        input  req_data,
        input  rsp_ready,
        output req_ready,
        output rsp_valid,
        output rsp_id,
        output rsp_count
    );

endinterface

// File: rtl/seq_detect_sched_rr_arbiter.sv
// Round-robin picker: first valid requester after last_grant, wrapping.
// Purely combinational; the caller owns the last_grant register.
module rr_arbiter
    import seq_sched_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [ID_W-1:0]  last_grant_i,
    output logic [N_REQ-1:0] grant_o
);

    always_comb begin
        int              pos;
        logic            found;
        logic [ID_W-1:0] sel;
        grant_o = '0;
        found   = 1'b0;
        pos     = 0;
        sel     = '0;
        // k = N_REQ revisits last_grant itself, so a lone requester wins
        for (int k = 1; k <= N_REQ; k++) begin
            pos = (int'(last_grant_i) + k) % N_REQ;
            sel = ID_W'(pos);
            if (!found && req_i[sel]) begin
                grant_o[sel] = 1'b1;
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seq_detect_sched.sv
// Shares one serial run-of-ones detector among N_REQ word requesters.
// Words are shifted MSB-first; the hit count is returned tagged with id.
module seq_detect_sched
    import seq_sched_pkg::*;
#(
    parameter int N_REQ   = DEF_N_REQ,
    parameter int WORD_W  = DEF_WORD_W,
    parameter int RUN_LEN = DEF_RUN_LEN,
    parameter int ID_W    = $clog2(N_REQ),
    parameter int CNT_W   = $clog2(WORD_W + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    seq_detect_sched_if.slave bus,
    output logic              busy
);

    localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int RUN_W = $clog2(RUN_LEN + 1);

    localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(RUN_LEN);
    localparam logic [RUN_W-1:0] RUN_HIT  = RUN_W'(RUN_LEN - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_W - 1);
    localparam logic [ID_W-1:0]  LAST_RST = ID_W'(N_REQ - 1);

    logic [1:0]        state_q, state_d;
    logic [ID_W-1:0]   last_q, last_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [RUN_W-1:0]  run_q, run_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
    logic [CNT_W-1:0]  rsp_count_q, rsp_count_d;

    logic [N_REQ-1:0]  grant;
    logic [ID_W-1:0]   gidx;
    logic [WORD_W-1:0] gword;
    logic              accept;
    logic              bit_in;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .req_i        (bus.req_valid),
        .last_grant_i (last_q),
        .grant_o      (grant)
    );

    always_comb begin
        gidx  = '0;
        gword = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                gidx  = ID_W'(i);
                gword = bus.req_data[i*WORD_W +: WORD_W];
            end
        end
    end

    // Held low during reset so every output shows its reset value at once
    assign bus.req_ready = (state_q == IDLE && rst_n) ? grant : '0;
    assign accept        = |(bus.req_valid & bus.req_ready);

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        word_d      = word_q;
        idx_d       = idx_q;
        run_d       = run_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_count_d = rsp_count_q;
        bit_in      = word_q[WORD_W-1];
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    word_d      = gword;
                    rsp_id_d    = gidx;
                    last_d      = gidx;
                    run_d       = '0;
                    rsp_count_d = '0;
                    idx_d       = '0;
                    state_d     = SHIFT;
                end
            end
            SHIFT: begin
                word_d = word_q << 1;
                if (bit_in) begin
                    if (run_q >= RUN_HIT) begin
                        rsp_count_d = rsp_count_q + CNT_W'(1);
                    end
                    if (run_q != RUN_MAX) begin
                        run_d = run_q + RUN_W'(1);
                    end
                end else begin
                    run_d = '0;
                end
                if (idx_q == IDX_LAST) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_q      <= LAST_RST;
            word_q      <= '0;
            idx_q       <= '0;
            run_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_count_q <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            word_q      <= word_d;
            idx_q       <= idx_d;
            run_q       <= run_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_count_q <= rsp_count_d;
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_count = rsp_count_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_seq_detect_sched.sv
// Directed bench for seq_detect_sched with a queue-based scoreboard.
// Expected grants and hit counts come from an independent window model.
module tb_seq_detect_sched;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int R  = 3;
    localparam int IW = $clog2(N);
    localparam int CW = $clog2(W + 1);

    typedef struct {
        int id;
        int cnt;
    } exp_t;

    logic clk;
    logic rst_n;
    logic busy;

    exp_t sb_q[$];
    int   checks;
    int   errors;
    int   exp_last;
    int   hold_id;
    int   hold_cnt;

    seq_detect_sched_if #(
        .N_REQ  (N),
        .WORD_W (W)
    ) bus ();

    seq_detect_sched #(
        .N_REQ   (N),
        .WORD_W  (W),
        .RUN_LEN (R)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic int hits(input logic [W-1:0] w);
        int  n;
        bit  ok;
        n = 0;
        for (int p = R - 1; p < W; p++) begin
            ok = 1'b1;
            for (int q = 0; q < R; q++) begin
                if (!w[W-1-(p-q)]) ok = 1'b0;
            end
            if (ok) n++;
        end
        return n;
    endfunction

    function automatic int rr_pick(input int last, input logic [N-1:0] v);
        int j;
        for (int k = 1; k <= N; k++) begin
            j = (last + k) % N;
            if (v[j]) return j;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_word(input int r, input logic [W-1:0] w);
        bus.req_data[r*W +: W] = w;
    endtask

    // Grant/accept one word, then wait out the fixed latency and score it
    task automatic run_word();
        int           g;
        logic [N-1:0] oh;
        exp_t         e;
        @(negedge clk);
        g  = rr_pick(exp_last, bus.req_valid);
        oh = '0;
        if (g >= 0) oh[g] = 1'b1;
        chk("grant", 64'(bus.req_ready), 64'(oh));
        if (g < 0) return;
        e.id  = g;
        e.cnt = hits(bus.req_data[g*W +: W]);
        sb_q.push_back(e);
        exp_last = g;
        tick();
        chk("busy_shift", 64'(busy), 64'(1));
        chk("ready_shift", 64'(bus.req_ready), 64'(0));
        repeat (W - 1) tick();
        chk("early_rsp", 64'(bus.rsp_valid), 64'(0));
        tick();
        chk("latency", 64'(bus.rsp_valid), 64'(1));
        if (sb_q.size() == 0) begin
            chk("sb_underflow", 64'(0), 64'(1));
            return;
        end
        e = sb_q.pop_front();
        hold_id  = e.id;
        hold_cnt = e.cnt;
        chk("rsp_id", 64'(bus.rsp_id), 64'(e.id));
        chk("rsp_count", 64'(bus.rsp_count), 64'(e.cnt));
    endtask

    task automatic finish_rsp();
        bus.rsp_ready = 1'b1;
        tick();
        chk("rsp_drop", 64'(bus.rsp_valid), 64'(0));
        chk("busy_idle", 64'(busy), 64'(0));
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        exp_last      = N - 1;
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 64'(bus.req_ready), 64'(0));
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        chk("rst_rsp_id", 64'(bus.rsp_id), 64'(0));
        chk("rst_rsp_count", 64'(bus.rsp_count), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        rst_n = 1'b1;
        tick();

        // single requester, assorted patterns
        bus.req_valid = 4'b0001;
        set_word(0, 8'b1111_0111); run_word(); finish_rsp();
        set_word(0, 8'hFF);        run_word(); finish_rsp();
        set_word(0, 8'h00);        run_word(); finish_rsp();
        set_word(0, 8'b1101_1011); run_word(); finish_rsp();
        set_word(0, 8'b1110_0000); run_word(); finish_rsp();

        // consumer back-pressure
        bus.req_valid = 4'b0010;
        set_word(1, 8'b0111_1110);
        bus.rsp_ready = 1'b0;
        run_word();
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_valid", 64'(bus.rsp_valid), 64'(1));
            chk("hold_id", 64'(bus.rsp_id), 64'(hold_id));
            chk("hold_count", 64'(bus.rsp_count), 64'(hold_cnt));
            chk("hold_busy", 64'(busy), 64'(1));
            chk("hold_ready", 64'(bus.req_ready), 64'(0));
        end
        finish_rsp();

        // no carry of runs between words
        set_word(1, 8'b0000_0011); run_word(); finish_rsp();
        set_word(1, 8'b1000_0000); run_word(); finish_rsp();

        // async reset in the middle of a word
        bus.req_valid = 4'b0100;
        set_word(2, 8'hFF);
        @(negedge clk);
        chk("grant_r2", 64'(bus.req_ready), 64'(4'b0100));
        tick();
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", 64'(bus.req_ready), 64'(0));
        chk("mid_rst_valid", 64'(bus.rsp_valid), 64'(0));
        chk("mid_rst_id", 64'(bus.rsp_id), 64'(0));
        chk("mid_rst_count", 64'(bus.rsp_count), 64'(0));
        chk("mid_rst_busy", 64'(busy), 64'(0));
        bus.req_valid = '0;
        exp_last = N - 1;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < W + 4; i++) begin
            tick();
            chk("no_rsp_after_rst", 64'(bus.rsp_valid), 64'(0));
        end

        // all four continuously valid: 0,1,2,3,0
        set_word(0, 8'b0111_0000);
        set_word(1, 8'b1111_1100);
        set_word(2, 8'b0000_0000);
        set_word(3, 8'b1111_0000);
        bus.req_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            run_word();
            finish_rsp();
        end

        // lone requester 3, second grant needs the wrap-around search
        bus.req_valid = 4'b1000;
        set_word(3, 8'b0011_1000); run_word(); finish_rsp();
        set_word(3, 8'hFF);        run_word(); finish_rsp();
        bus.req_valid = '0;

        chk("sb_empty", 64'(sb_q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_detect_sched.md
Name: seq_detect_sched

Overview:
- Shares one serial run-of-ones detector between N_REQ requesters.
- Each requester submits a WORD_W-bit word over a valid/ready handshake. A round-robin arbiter picks one word, which is shifted MSB-first through the detector, one bit per clock.
- The block then returns the number of bit positions at which the detector fired, tagged with the requester id.
- Sits between the per-channel word sources and the serial pattern-detection datapath.

Parameters:
- N_REQ, 4, number of requesters (>=2)
- WORD_W, 8, bits per submitted word (>=RUN_LEN)
- RUN_LEN, 3, number of consecutive 1s that make the detector fire
- ID_W, $clog2(N_REQ), width of the requester id
- CNT_W, $clog2(WORD_W+1), width of the match count

Ports:
- clk, input, 1, rising-edge clock, single clock domain
- rst_n, input, 1, asynchronous active-low reset
- req_valid, input, N_REQ, per-requester word valid
- req_data, input, N_REQ*WORD_W, word of requester i at bits [i*WORD_W +: WORD_W]
- req_ready, output, N_REQ, one-hot grant/accept; at most one bit high
- rsp_valid, output, 1, result available
- rsp_id, output, ID_W, requester whose word produced the result
- rsp_count, output, CNT_W, number of detector hits in the word
- rsp_ready, input, 1, consumer accepts the result
- busy, output, 1, high in every state other than IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, req_ready=0, rsp_valid=0, rsp_id=0, rsp_count=0, busy=0, run counter=0, bit index=0, last_grant=N_REQ-1 (so requester 0 has first priority).
- FSM states: IDLE -> SHIFT -> RESP -> IDLE.
- IDLE:
  - req_ready is combinational: the one-hot of the first i with req_valid[i]=1, searching from last_grant+1 upward with wrap-around.
  - If no requester is valid, req_ready=0.
  - On an edge with req_valid[g] & req_ready[g]: capture req_data word g and id g, set last_grant<=g, clear the run counter, hit count and bit index, and go to SHIFT.
- SHIFT:
  - req_ready=0.
  - Each edge consumes bit WORD_W-1-idx of the captured word.
  - Run counter: 0 on a 0 bit; on a 1 bit it increments, saturating at RUN_LEN.
  - A hit occurs on a bit that is 1 while the run counter before the update is >= RUN_LEN-1; a hit increments rsp_count.
  - After the edge that consumes idx=WORD_W-1, go to RESP.
- Latency: rsp_valid rises exactly WORD_W edges after the accept edge.
- RESP:
  - rsp_valid=1; rsp_id and rsp_count are stable and held while rsp_valid=1 && rsp_ready=0.
  - On an edge with rsp_ready=1, drop rsp_valid and return to IDLE.
  - rsp_count and rsp_id keep their last values until the next accept.
- Throughput: one word per WORD_W+2 cycles at most (no accept in the RESP->IDLE cycle overlap).
- Detector state is per word: no runs carry across words. Overlapping runs count: a run of k>=RUN_LEN ones yields k-RUN_LEN+1 hits.
- Requester deasserting req_valid while not granted: allowed; it is simply not picked.
- Requester changing req_data while not granted: allowed; data is sampled only on the accept edge.
- Simultaneous valids: round-robin as above. A requester that is continuously valid is served within N_REQ grants.
- rst_n asserted mid-operation: immediate return to reset values; the in-flight word is dropped and no response is produced.
- Outputs are registered except req_ready (combinational from state, req_valid and last_grant).

Decomposition:
- Shared package seq_sched_pkg holds:
  - state encoding constants IDLE=2'd0, SHIFT=2'd1, RESP=2'd2
  - default N_REQ, WORD_W, RUN_LEN values
- One sub-module, rr_arbiter (N_REQ): inputs req vector and last_grant; output one-hot grant.
- The run counter and hit logic stay inline.

Test Plan:
- Single requester: req0 sends 8'b1111_0111 -> accept at edge E, rsp_valid at E+8, rsp_id=0, rsp_count=3; then 8'hFF -> 6; 8'h00 -> 0; 8'b1101_1011 -> 0; 8'b1110_0000 -> 1.
- All four requesters valid continuously with distinct words -> grants in order 0,1,2,3,0; each response id matches its word's count; req_ready is never more than one-hot.
- Consumer holds rsp_ready=0 for 5 cycles -> rsp_valid/id/count are stable, busy=1, no new req_ready; releasing rsp_ready returns to IDLE the next edge.
- Runs do not carry across words: req1 sends 8'b0000_0011, then req1 sends 8'b1000_0000 -> counts 0 and 0.
- rst_n pulsed low asynchronously during SHIFT of req2's word -> all outputs read reset values immediately, no rsp_valid afterwards; the first grant after reset goes to the lowest valid requester starting from 0.
- req3 only valid while last_grant=3 -> req3 is still granted (wrap-around search); response id=3.
